// File: rtl/booth_dot_acc_if.sv
// Handshake bundle between the Booth multiplier stream and the dot-product accumulator.
// The master drives products and consumes results; the slave is the accumulator.
interface booth_dot_acc_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12
) ();
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              sat;
    logic [7:0]        terms;

    modport master (
        output in_valid, prod, in_last, out_ready,
        input  in_ready, out_valid, acc_out, sat, terms
    );

    modport slave (
        input  in_valid, prod, in_last, out_ready,
        output in_ready, out_valid, acc_out, sat, terms
    );
endinterface

// File: rtl/booth_dot_acc.sv
// Saturating signed dot-product accumulator: sums up to N_TERMS products per frame
// and hands the frame result downstream over valid/ready.
module booth_dot_acc #(
    parameter int unsigned PROD_W  = 8,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned N_TERMS = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clear,
    booth_dot_acc_if.slave bus
);
    typedef enum logic [0:0] {StAcc, StDone} state_e;

    localparam logic [ACC_W-1:0] AccMax  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]       LastCnt = 8'(N_TERMS - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               accept;
    logic               close;
    logic [ACC_W:0]     sum_wide;
    logic               ovf;
    logic [ACC_W-1:0]   acc_sum;

    assign bus.in_ready  = rst_n & ~clear & (state_q == StAcc);
    assign bus.out_valid = (state_q == StDone);
    assign bus.acc_out   = acc_q;
    assign bus.sat       = sat_q;
    assign bus.terms     = cnt_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign close  = accept & (bus.in_last | (cnt_q == LastCnt));

    // One guard bit makes the exact sum representable; sign bits disagreeing means overflow.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W + 1 - PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
        ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        acc_sum  = ovf ? (sum_wide[ACC_W] ? AccMin : AccMax) : sum_wide[ACC_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = StAcc;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (state_q == StDone) begin
            if (bus.out_ready) begin
                state_d = StAcc;
                acc_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        end else if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 8'd1;
            sat_d = sat_q | ovf;
            if (close) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_booth_dot_acc.sv
// Drives one product stream into a 12-bit and an 8-bit accumulator and checks both
// against a saturating integer model with a queue of expected frame results.
module tb_booth_dot_acc;
    localparam int N_TERMS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] prod = 8'd0;

    booth_dot_acc_if #(.PROD_W(8), .ACC_W(12)) ifa ();
    booth_dot_acc_if #(.PROD_W(8), .ACC_W(8))  ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.prod      = prod;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.prod      = prod;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    booth_dot_acc #(.PROD_W(8), .ACC_W(12), .N_TERMS(N_TERMS)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (ifa)
    );

    booth_dot_acc #(.PROD_W(8), .ACC_W(8), .N_TERMS(N_TERMS)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        bit sat;
        int terms;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc[2] = '{0, 0};
    bit   m_sat[2] = '{1'b0, 1'b0};
    int   m_cnt = 0;
    bit   m_done = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int i, input logic rdy, input logic vld, input int acc,
                           input logic s, input int t);
        string nm;
        bit    exp_rdy;
        res_t  r;
        nm      = (i == 0) ? "w12" : "w8";
        exp_rdy = rst_n && !clear && !m_done;
        chk({nm, ".in_ready"}, int'(rdy), int'(exp_rdy));
        chk({nm, ".out_valid"}, int'(vld), int'(m_done));
        if (m_done) begin
            chk({nm, ".q_nonempty"}, ((i == 0) ? q_a.size() : q_b.size()) > 0 ? 1 : 0, 1);
            if (((i == 0) ? q_a.size() : q_b.size()) > 0) begin
                r = (i == 0) ? q_a[0] : q_b[0];
                chk({nm, ".acc_out"}, acc, r.acc);
                chk({nm, ".sat"}, int'(s), int'(r.sat));
                chk({nm, ".terms"}, t, r.terms);
            end
        end else begin
            chk({nm, ".acc_run"}, acc, m_acc[i]);
            chk({nm, ".sat_run"}, int'(s), int'(m_sat[i]));
            chk({nm, ".cnt_run"}, t, m_cnt);
        end
    endtask

    task automatic model_reset();
        m_acc  = '{0, 0};
        m_sat  = '{1'b0, 1'b0};
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    // Check outputs on the falling edge, advance the model, then let the rising edge happen.
    task automatic step();
        int   s;
        int   hi;
        int   lo;
        res_t r;
        @(negedge clk);
        chk_dut(0, ifa.in_ready, ifa.out_valid, int'($signed(ifa.acc_out)), ifa.sat,
                int'(ifa.terms));
        chk_dut(1, ifb.in_ready, ifb.out_valid, int'($signed(ifb.acc_out)), ifb.sat,
                int'(ifb.terms));
        if (!rst_n || clear) begin
            model_reset();
            q_a.delete();
            q_b.delete();
        end else if (m_done) begin
            if (out_ready) begin
                if (q_a.size() > 0) void'(q_a.pop_front());
                if (q_b.size() > 0) void'(q_b.pop_front());
                model_reset();
            end
        end else if (in_valid) begin
            for (int i = 0; i < 2; i++) begin
                hi = (i == 0) ? 2047 : 127;
                lo = (i == 0) ? -2048 : -128;
                s  = m_acc[i] + int'($signed(prod));
                if (s > hi) begin
                    s = hi;
                    m_sat[i] = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    m_sat[i] = 1'b1;
                end
                m_acc[i] = s;
            end
            m_cnt++;
            if (in_last || m_cnt == N_TERMS) begin
                r.terms = m_cnt;
                r.acc = m_acc[0];
                r.sat = m_sat[0];
                q_a.push_back(r);
                r.acc = m_acc[1];
                r.sat = m_sat[1];
                q_b.push_back(r);
                m_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input bit last = 1'b0);
        in_valid = 1'b1;
        prod     = 8'(p);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back frame, consumer always ready
        out_ready = 1'b1;
        send(6); send(-8); send(49); send(-64);
        idle(2);

        // Early close via in_last, result held while consumer stalls, in_valid pending
        out_ready = 1'b0;
        send(64); send(64, 1'b1);
        in_valid = 1'b1;
        prod     = 8'd33;
        idle(5);
        out_ready = 1'b1;
        idle(1);
        in_valid = 1'b0;
        idle(1);

        // Positive clamp then recovery; next frame closes on in_last and count together
        send(64); send(64); send(-1); send(0);
        idle(2);
        send(1); send(1); send(1); send(1, 1'b1);
        idle(2);

        // Negative clamp including the most negative product
        send(-64); send(-64); send(-64); send(64);
        idle(1);
        send(-128); send(-128, 1'b1);
        idle(2);

        // Clear mid-frame with a concurrent product that must be dropped
        send(10); send(20);
        clear    = 1'b1;
        in_valid = 1'b1;
        prod     = 8'd5;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        idle(1);
        send(1); send(2); send(3); send(4);
        idle(2);

        // Clear in DONE discards the result even with out_ready high
        send(9, 1'b1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        idle(1);

        // Reset while a result is pending
        out_ready = 1'b0;
        send(7); send(7); send(7); send(7);
        idle(1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        prod     = 8'd9;
        idle(1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(1);
        out_ready = 1'b1;
        send(7); send(7); send(7); send(7);
        idle(2);

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
